// File: rtl/sincos_interp_feeder_pkg.sv
// ============================================================================
// sincos_interp_feeder_pkg : shared widths, quadrant/LUT types, LUT image and
//                            quadrant negation helper for the sine feeder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sincos_interp_feeder_pkg;

    localparam int c_PHASE_W     = 32;
    localparam int c_LUT_AW      = 8;
    localparam int c_FRAC_W      = 17;
    localparam int c_DATA_W      = 18;
    localparam int c_MUL_C_W     = 48;
    localparam int c_FULL_SCALE  = (1 << (c_DATA_W - 1)) - 1;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_t;

    typedef struct packed {
        logic signed [c_DATA_W-1:0] base;
        logic signed [c_DATA_W-1:0] slope;
    } lut_word_t;

    // Quarter-wave sample t of 2^aw: Bhaskara sine, sin = 4u/(5N^2-u), u = t(2N-t).
    // Exact at t=0 (0) and t=N (+full scale), so slope[N-1] reaches full scale.
    function automatic logic signed [c_DATA_W-1:0] lut_base(input int t, input int aw);
        longint n;
        longint u;
        longint num;
        longint den;
        n   = longint'(1) << aw;
        u   = longint'(t) * (2 * n - longint'(t));
        num = longint'(c_FULL_SCALE) * 4 * u;
        den = 5 * n * n - u;
        return c_DATA_W'(num / den);
    endfunction

    function automatic lut_word_t lut_entry(input int i, input int aw);
        lut_word_t w;
        w.base  = lut_base(i, aw);
        w.slope = lut_base(i + 1, aw) - w.base;
        return w;
    endfunction

    // Lower half-wave: flip both terms so slope*frac + base comes out negative.
    function automatic lut_word_t negate_word(input lut_word_t w, input logic neg);
        lut_word_t r;
        r.base  = neg ? -w.base  : w.base;
        r.slope = neg ? -w.slope : w.slope;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sincos_interp_feeder_if.sv
// ============================================================================
// sincos_interp_feeder_if : phase control inputs and A/B/C multiplier feed.
// cos_sel exists only when SINCOS_COS_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sincos_interp_feeder_if
    import sincos_interp_feeder_pkg::*;
#(
    parameter int PHASE_W = c_PHASE_W
);
    logic                          en;
    logic [PHASE_W-1:0]            phase_inc;
    logic                          phase_load;
    logic [PHASE_W-1:0]            phase_init;
`ifdef SINCOS_COS_EN
    logic                          cos_sel;
`endif
    logic signed [c_DATA_W-1:0]    mul_a;
    logic        [c_DATA_W-1:0]    mul_b;
    logic signed [c_MUL_C_W-1:0]   mul_c;
    logic [1:0]                    out_quad;
    logic                          out_valid;

    modport master (
`ifdef SINCOS_COS_EN
        output cos_sel,
`endif
        output en,
        output phase_inc,
        output phase_load,
        output phase_init,
        input  mul_a,
        input  mul_b,
        input  mul_c,
        input  out_quad,
        input  out_valid
    );

    modport slave (
`ifdef SINCOS_COS_EN
        input  cos_sel,
`endif
        input  en,
        input  phase_inc,
        input  phase_load,
        input  phase_init,
        output mul_a,
        output mul_b,
        output mul_c,
        output out_quad,
        output out_valid
    );

endinterface

`default_nettype wire

// File: rtl/sincos_interp_feeder_quarter_rom.sv
// ============================================================================
// sincos_quarter_rom : quarter-wave {base,slope} table, 1-cycle synchronous
//                      read, data register not reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sincos_quarter_rom
    import sincos_interp_feeder_pkg::*;
#(
    parameter int LUT_AW = c_LUT_AW
) (
    input  wire logic              clk,
    input  wire logic              rd_en,
    input  wire logic [LUT_AW-1:0] addr,
    output lut_word_t              rd_data
);

    localparam int c_DEPTH = 1 << LUT_AW;

    lut_word_t rom [c_DEPTH];
    lut_word_t rd_data_q;
    lut_word_t rd_data_d;

    // Table image is fixed at elaboration, so it maps onto a plain ROM.
    for (genvar g = 0; g < c_DEPTH; g++) begin : g_rom
        localparam lut_word_t c_WORD = lut_entry(g, LUT_AW);
        assign rom[g] = c_WORD;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = rom[addr];
        end
    end

    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/sincos_interp_feeder.sv
// ============================================================================
// sincos_interp_feeder : phase accumulator, quadrant fold, quarter-wave fetch
//                        and A/B/C alignment for the A*B+C interpolator.
// Optional cosine select when SINCOS_COS_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sincos_interp_feeder
    import sincos_interp_feeder_pkg::*;
#(
    parameter int PHASE_W = c_PHASE_W,
    parameter int LUT_AW  = c_LUT_AW,
    parameter int FRAC_W  = c_FRAC_W
) (
    input  wire logic             clk,
    input  wire logic             resetn,
    sincos_interp_feeder_if.slave bus
);

    localparam int c_IDX_MSB  = PHASE_W - 3;
    localparam int c_FRAC_MSB = PHASE_W - 3 - LUT_AW;
    localparam int c_SEXT_W   = c_MUL_C_W - c_DATA_W - FRAC_W;

    logic [PHASE_W-1:0]        acc_q, acc_d;
    logic [PHASE_W-1:0]        sample_phase;
    quad_t                     quad_eff;
    logic [LUT_AW-1:0]         idx_fold;
    logic [FRAC_W-1:0]         frac_fold;

    logic [LUT_AW-1:0]         s1_idx_q, s1_idx_d;
    logic [FRAC_W-1:0]         s1_frac_q, s1_frac_d;
    quad_t                     s1_quad_q, s1_quad_d;
    logic                      s1_v_q, s1_v_d;

    logic [FRAC_W-1:0]         s2_frac_q, s2_frac_d;
    quad_t                     s2_quad_q, s2_quad_d;
    logic                      s2_v_q, s2_v_d;
    lut_word_t                 rom_word;
    lut_word_t                 word_n;

    logic [c_DATA_W-1:0]       mul_a_q, mul_a_d;
    logic [c_DATA_W-1:0]       mul_b_q, mul_b_d;
    logic [c_MUL_C_W-1:0]      mul_c_q, mul_c_d;
    quad_t                     out_quad_q, out_quad_d;
    logic                      out_valid_q, out_valid_d;

    always_comb begin
        sample_phase = bus.phase_load ? bus.phase_init : acc_q;
        acc_d        = acc_q;
        if (bus.en) begin
            acc_d = sample_phase + bus.phase_inc;
        end else if (bus.phase_load) begin
            acc_d = bus.phase_init;
        end
    end

    // Cosine is sine a quarter turn ahead; only the emitted quadrant moves.
`ifdef SINCOS_COS_EN
    assign quad_eff = quad_t'(sample_phase[PHASE_W-1 -: 2] + {1'b0, bus.cos_sel});
`else
    assign quad_eff = quad_t'(sample_phase[PHASE_W-1 -: 2]);
`endif

    always_comb begin
        idx_fold  = sample_phase[c_IDX_MSB  -: LUT_AW];
        frac_fold = sample_phase[c_FRAC_MSB -: FRAC_W];
        if (quad_eff[0]) begin
            idx_fold  = ~idx_fold;
            frac_fold = ~frac_fold;
        end
    end

    always_comb begin
        s1_v_d    = bus.en;
        s1_idx_d  = s1_idx_q;
        s1_frac_d = s1_frac_q;
        s1_quad_d = s1_quad_q;
        if (bus.en) begin
            s1_idx_d  = idx_fold;
            s1_frac_d = frac_fold;
            s1_quad_d = quad_eff;
        end
    end

    sincos_quarter_rom #(
        .LUT_AW (LUT_AW)
    ) u_rom (
        .clk     (clk),
        .rd_en   (s1_v_q),
        .addr    (s1_idx_q),
        .rd_data (rom_word)
    );

    always_comb begin
        s2_v_d    = s1_v_q;
        s2_frac_d = s2_frac_q;
        s2_quad_d = s2_quad_q;
        if (s1_v_q) begin
            s2_frac_d = s1_frac_q;
            s2_quad_d = s1_quad_q;
        end
    end

    assign word_n = negate_word(rom_word, s2_quad_q[1]);

    always_comb begin
        out_valid_d = s2_v_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_c_d     = mul_c_q;
        out_quad_d  = out_quad_q;
        if (s2_v_q) begin
            mul_a_d    = word_n.slope;
            mul_b_d    = c_DATA_W'(s2_frac_q);
            mul_c_d    = {{c_SEXT_W{word_n.base[c_DATA_W-1]}}, word_n.base, {FRAC_W{1'b0}}};
            out_quad_d = s2_quad_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q       <= '0;
            s1_idx_q    <= '0;
            s1_frac_q   <= '0;
            s1_quad_q   <= Q0;
            s1_v_q      <= 1'b0;
            s2_frac_q   <= '0;
            s2_quad_q   <= Q0;
            s2_v_q      <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_c_q     <= '0;
            out_quad_q  <= Q0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            s1_idx_q    <= s1_idx_d;
            s1_frac_q   <= s1_frac_d;
            s1_quad_q   <= s1_quad_d;
            s1_v_q      <= s1_v_d;
            s2_frac_q   <= s2_frac_d;
            s2_quad_q   <= s2_quad_d;
            s2_v_q      <= s2_v_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_c_q     <= mul_c_d;
            out_quad_q  <= out_quad_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.mul_c     = mul_c_q;
    assign bus.out_quad  = out_quad_q;
    assign bus.out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_sincos_interp_feeder.sv
// ============================================================================
// tb_sincos_interp_feeder : directed and random phase stimulus against a
//                           sine-table/queue reference of the feeder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sincos_interp_feeder;

    logic clk    = 1'b0;
    logic resetn = 1'b1;

    sincos_interp_feeder_if #(.PHASE_W(32)) bus ();

    sincos_interp_feeder u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned  due;
        logic [17:0]  a;
        logic [17:0]  b;
        logic [47:0]  c;
        logic [1:0]   quad;
    } exp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc      = 0;
    int          tb_base [0:256];
    logic [31:0] acc_m    = '0;
    exp_t        exp_q [$];
    exp_t        last_exp;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Expected multiplier feed for a phase, straight from the sine-table rules.
    function automatic exp_t expect_of(input logic [31:0] p, input bit cs);
        exp_t        e;
        logic [1:0]  q;
        int          idx;
        logic [16:0] fr;
        int          b;
        int          s;
        q   = p[31:30] + {1'b0, cs};
        idx = int'(p[29:22]);
        fr  = p[21:5];
        if (q[0]) begin
            idx = 255 - idx;
            fr  = 17'h1FFFF - fr;
        end
        b = tb_base[idx];
        s = tb_base[idx + 1] - tb_base[idx];
        if (q[1]) begin
            b = -b;
            s = -s;
        end
        e.due  = 0;
        e.a    = 18'(s);
        e.b    = {1'b0, fr};
        e.c    = 48'(longint'(b) * 131072);
        e.quad = q;
        return e;
    endfunction

    task automatic check_outputs();
        bit v_exp;
        v_exp = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check_val("out_valid", {63'b0, bus.out_valid}, {63'b0, v_exp});
        if (v_exp) begin
            last_exp = exp_q.pop_front();
        end
        check_val("mul_a",    {46'b0, bus.mul_a},    {46'b0, last_exp.a});
        check_val("mul_b",    {46'b0, bus.mul_b},    {46'b0, last_exp.b});
        check_val("mul_c",    {16'b0, bus.mul_c},    {16'b0, last_exp.c});
        check_val("out_quad", {62'b0, bus.out_quad}, {62'b0, last_exp.quad});
    endtask

    task automatic model_reset();
        exp_q.delete();
        acc_m       = '0;
        last_exp    = '{default: '0};
    endtask

    task automatic drive_cycle(input bit en, input bit ld, input bit cs,
                               input logic [31:0] inc, input logic [31:0] init);
        logic [31:0] p;
        exp_t        e;
        bit          cs_used;
        bus.en         = en;
        bus.phase_load = ld;
        bus.phase_inc  = inc;
        bus.phase_init = init;
`ifdef SINCOS_COS_EN
        bus.cos_sel    = cs;
        cs_used        = cs;
`else
        cs_used        = 1'b0;
`endif
        if (resetn) begin
            p = ld ? init : acc_m;
            if (en) begin
                e     = expect_of(p, cs_used);
                e.due = cyc + 3;
                exp_q.push_back(e);
                acc_m = p + inc;
            end else if (ld) begin
                acc_m = init;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, $urandom, $urandom);
    endtask

    task automatic hit_reset(input int n);
        resetn = 1'b0;
        model_reset();
        #1;
        check_outputs();
        for (int i = 0; i < n; i++) drive_cycle(1, $urandom_range(0, 1), 0, $urandom, $urandom);
        resetn = 1'b1;
    endtask

    initial begin
        for (int t = 0; t <= 256; t++) begin
            real u;
            u          = real'(t) * (512.0 - real'(t));
            tb_base[t] = int'($floor(131071.0 * 4.0 * u / (327680.0 - u)));
        end
        model_reset();
        bus.en         = 1'b0;
        bus.phase_load = 1'b0;
        bus.phase_inc  = '0;
        bus.phase_init = '0;
`ifdef SINCOS_COS_EN
        bus.cos_sel    = 1'b0;
`endif
        #2;
        // Reset held with en asserted, then released into idle.
        hit_reset(4);
        idle(3);

        // Phase 0, quadrant-1 mirror point, and negative half-wave.
        drive_cycle(1, 1, 0, 32'h0, 32'h0000_0000);
        idle(4);
        drive_cycle(1, 1, 0, 32'h0, 32'h4000_0000);
        idle(4);
        drive_cycle(1, 1, 0, 32'h0, 32'h8000_0000);
        idle(4);
        drive_cycle(1, 1, 0, 32'h0, 32'hC012_3456);
        idle(4);
`ifdef SINCOS_COS_EN
        drive_cycle(1, 1, 1, 32'h0, 32'h0000_0000);
        idle(4);
`endif
        // Load without en must not emit a sample.
        drive_cycle(0, 1, 0, 32'h0, 32'h2000_0000);
        drive_cycle(1, 0, 0, 32'h0, 32'h0);
        idle(4);

        // Full-rate sweep across all quadrants with wrap.
        drive_cycle(1, 1, 0, 32'h0100_0000, 32'h0);
        for (int i = 0; i < 299; i++) drive_cycle(1, 0, 0, 32'h0100_0000, 32'h0);

        // Reset with samples in flight, then accumulator restarts from 0.
        hit_reset(2);
        for (int i = 0; i < 6; i++) drive_cycle(1, 0, 0, 32'h0345_6789, 32'h0);
        idle(4);

        for (int i = 0; i < 600; i++) begin
            drive_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                        $urandom_range(0, 1), $urandom, $urandom);
            if (i == 300) hit_reset(1);
        end
        idle(5);
        check_val("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
